muldiv_alu: RTL and testbench
=============================

MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, with one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operation request.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-006 The block SHALL have port op, input, 5, operation select (encoding REQ-011).
REQ-007 The block SHALL have ports a and b, input, XLEN each, operands A and B.
REQ-008 The block SHALL have port out_valid, output, 1, one-cycle pulse marking result/zero valid.
REQ-009 The block SHALL have port result, output, XLEN, registered result.
REQ-010 The block SHALL have ports zero (1, result == 0, registered with result) and busy (1, multi-cycle operation in progress), both outputs.

Function
REQ-011 Op encoding SHALL be:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL (logical), 7 SRA (arithmetic), 8 OR, 9 AND.
- 10 MUL (low XLEN), 11 MULH (s×s high), 12 MULHSU (s×u high), 13 MULHU (u×u high).
- 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- 18–31 reserved: result 0, zero 1, single-cycle timing.
REQ-012 A request SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; op/a/b SHALL be captured at acceptance, and later input changes SHALL not affect the operation.
REQ-013 Shifts SHALL use b[log2(XLEN)-1:0] as the amount; SLT and SLTU SHALL return 1 or 0 zero-extended to XLEN.
REQ-014 Ops 0–9 and reserved ops SHALL be single-cycle:
- out_valid asserts on the cycle after acceptance.
- in_ready stays 1, so back-to-back acceptance every cycle is allowed.
REQ-015 The control FSM SHALL have states IDLE, MUL, DIV and FIX:
- IDLE→MUL on accepting ops 10–13; IDLE→DIV on accepting ops 14–17.
- MUL/DIV run exactly XLEN iterations (one bit per cycle, shift-add / restoring) counted by an iteration counter, then go to FIX.
- FIX applies sign correction and special-case override, registers the result, and goes to IDLE.
REQ-016 Multi-cycle ops SHALL have a fixed latency:
- out_valid asserts exactly XLEN+2 cycles after the acceptance cycle.
- This holds regardless of operand values, including special cases.
REQ-017 in_ready SHALL be 0 and busy SHALL be 1 from the cycle after a multi-cycle acceptance through the FIX cycle.
REQ-018 in_ready SHALL return to 1 in the same cycle out_valid asserts, allowing a new acceptance on that cycle.
REQ-019 Signed operations SHALL use two's-complement magnitudes internally, with the sign applied in FIX; MULHSU SHALL treat a as signed and b as unsigned.
REQ-020 Divide by zero SHALL return:
- DIV/DIVU: all ones.
- REM/REMU: a.
REQ-021 Signed overflow (a = most-negative value, b = −1) SHALL return:
- DIV: a.
- REM: 0.
REQ-022 The non-zero remainder SHALL take the sign of the dividend.
REQ-023 result and zero SHALL hold their last values until the next out_valid; out_valid SHALL never be asserted for two consecutive cycles by one request.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL set:
- state to IDLE, counter to 0.
- out_valid 0, result 0, zero 1, busy 0.
REQ-025 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after rst_n returns to 1.
REQ-026 Reset during MUL, DIV or FIX SHALL abort the operation without any out_valid pulse; the discarded operation's result SHALL never appear.

Verification
REQ-027 (XLEN=32) ADD a=0xFFFFFFFF, b=1 -> next cycle out_valid=1, result=0, zero=1; then SUB 5−7 on the following cycle -> result=0xFFFFFFFE, zero=0.
REQ-028 (XLEN=32) SRA a=0x80000000, b=0x24 (shift 4) -> result 0xF8000000; SRL with the same operands -> 0x08000000; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-029 (XLEN=32) MULHU a=b=0xFFFFFFFF -> out_valid exactly 34 cycles after acceptance, result 0xFFFFFFFE; in_ready=0 for cycles 1–33; MULH a=b=0xFFFFFFFF -> 0; MUL -> 1.
REQ-030 (XLEN=32) DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7; all after 34 cycles.
REQ-031 (XLEN=32) DIV a=−7, b=2 -> −3 (0xFFFFFFFD); REM with the same operands -> −1; in_valid held high with a new ADD request during busy -> not accepted until the out_valid cycle.
REQ-032 Assert rst_n=0 for one cycle 10 cycles into a DIVU -> no out_valid, in_ready=1 on the next cycle; with XLEN=8, MULHU 0xFF×0xFF -> 0xFE at latency 10.

Source files
------------

// File: rtl/muldiv_alu_if.sv
// Request/response bundle for muldiv_alu: request handshake, operands and registered result.
interface muldiv_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/muldiv_alu.sv
// Integer ALU with single-cycle logic/arith ops and a bit-serial multiplier/divider
// whose latency is fixed at XLEN+2 cycles regardless of operand values.
module muldiv_alu #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_alu_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    iter_q;
    logic              in_ready, accept, is_mul, is_div, last_iter;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_result;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q, opnd_q, acc_hi, acc_lo;
    logic              b_zero_q, ovf_q, q_neg_q, r_neg_q;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    logic              out_valid_q, zero_q;
    logic [XLEN-1:0]   result_q;

    assign in_ready      = rst_n && (state_q == IDLE);
    assign accept        = bus.in_valid && in_ready;
    assign is_mul        = (bus.op >= OP_MUL) && (bus.op <= OP_MULHU);
    assign is_div        = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
    assign last_iter     = (iter_q == SHW'(XLEN - 1));
    assign shamt         = bus.b[SHW-1:0];

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = MUL;
                end else if (accept && is_div) begin
                    state_d = DIV;
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (bus.op)
            OP_ADD:  alu_result = bus.a + bus.b;
            OP_SUB:  alu_result = bus.a - bus.b;
            OP_SLL:  alu_result = bus.a << shamt;
            OP_SLT:  alu_result = XLEN'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: alu_result = XLEN'(bus.a < bus.b);
            OP_XOR:  alu_result = bus.a ^ bus.b;
            OP_SRL:  alu_result = bus.a >> shamt;
            OP_SRA:  alu_result = $signed(bus.a) >>> shamt;
            OP_OR:   alu_result = bus.a | bus.b;
            OP_AND:  alu_result = bus.a & bus.b;
            default: alu_result = '0;
        endcase
    end

    // The iterative core works on magnitudes; the signs are remembered and applied in FIX.
    always_comb begin
        a_neg = bus.a[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                                  bus.op == OP_DIV  || bus.op == OP_REM);
        b_neg = bus.b[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM);
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
    end

    // Multiply: {acc_hi, acc_lo} is the shifting product, multiplier starts in acc_lo.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (accept && (is_mul || is_div)) begin
                    op_q     <= bus.op;
                    a_q      <= bus.a;
                    b_zero_q <= (bus.b == '0);
                    ovf_q    <= (bus.op == OP_DIV || bus.op == OP_REM) &&
                                (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
                    q_neg_q  <= a_neg ^ b_neg;
                    r_neg_q  <= a_neg;
                    opnd_q   <= is_mul ? a_mag : b_mag;
                    acc_hi   <= '0;
                    acc_lo   <= is_mul ? b_mag : a_mag;
                end
            end
            MUL: begin
                acc_hi <= mul_sum[XLEN:1];
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            DIV: begin
                acc_hi <= div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end
            default: ;
        endcase
    end

    always_comb begin
        prod       = {acc_hi, acc_lo};
        prod_fix   = q_neg_q ? -prod : prod;
        quo_fix    = q_neg_q ? -acc_lo : acc_lo;
        rem_fix    = r_neg_q ? -acc_hi : acc_hi;
        fix_result = '0;
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = b_zero_q ? '1  : (ovf_q ? a_q : quo_fix);
            OP_REM, OP_REMU:              fix_result = b_zero_q ? a_q : (ovf_q ? '0  : rem_fix);
            default:                      fix_result = '0;
        endcase
    end

    // Reset drops any in-flight operation; out_valid can only come from an accept or FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            iter_q      <= (state_q == MUL || state_q == DIV) ? iter_q + 1'b1 : '0;
            if (accept && !is_mul && !is_div) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_result;
                zero_q      <= (alu_result == '0);
            end else if (state_q == FIX) begin
                out_valid_q <= 1'b1;
                result_q    <= fix_result;
                zero_q      <= (fix_result == '0);
            end
        end
    end
endmodule

// File: tb/tb_muldiv_alu.sv
// Self-checking bench for muldiv_alu: directed vector table, hand-built timing sequences,
// and random operations checked against a wide-integer arithmetic reference model.
module tb_muldiv_alu;
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    muldiv_alu_if #(.XLEN(32)) bus32();
    muldiv_alu_if #(.XLEN(8))  bus8();

    muldiv_alu #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    muldiv_alu #(.XLEN(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain signed/unsigned arithmetic on 128-bit integers, masked to width w.
    function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [63:0] a_in,
                                              input logic [63:0] b_in, input int w);
        logic [63:0]        mask;
        logic signed [127:0] ua, ub, sa, sb, p, r, most_neg;
        int                 sh;
        mask     = (64'd1 << w) - 64'd1;
        ua       = $signed({64'd0, a_in & mask});
        ub       = $signed({64'd0, b_in & mask});
        sa       = ua[w-1] ? ua - (128'sd1 <<< w) : ua;
        sb       = ub[w-1] ? ub - (128'sd1 <<< w) : ub;
        most_neg = -(128'sd1 <<< (w - 1));
        sh       = int'(b_in & 64'(w - 1));
        r        = '0;
        case (op)
            5'd0:  r = ua + ub;
            5'd1:  r = ua - ub;
            5'd2:  r = ua << sh;
            5'd3:  r = (sa < sb) ? 128'sd1 : 128'sd0;
            5'd4:  r = (ua < ub) ? 128'sd1 : 128'sd0;
            5'd5:  r = ua ^ ub;
            5'd6:  r = ua >> sh;
            5'd7:  r = sa >>> sh;
            5'd8:  r = ua | ub;
            5'd9:  r = ua & ub;
            5'd10: r = ua * ub;
            5'd11: begin p = sa * sb; r = p >>> w; end
            5'd12: begin p = sa * ub; r = p >>> w; end
            5'd13: begin p = ua * ub; r = p >>> w; end
            5'd14: r = (sb == 0) ? -128'sd1 : ((sa == most_neg && sb == -128'sd1) ? sa : sa / sb);
            5'd15: r = (ub == 0) ? -128'sd1 : ua / ub;
            5'd16: r = (sb == 0) ? sa : ((sa == most_neg && sb == -128'sd1) ? 128'sd0 : sa % sb);
            5'd17: r = (ub == 0) ? ua : ua % ub;
            default: r = '0;
        endcase
        return r[63:0] & mask;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit narrow, input logic v, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (narrow) begin
            bus8.in_valid = v; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.in_valid = v; bus32.op = op; bus32.a = a[31:0]; bus32.b = b[31:0];
        end
    endtask

    function automatic logic get_valid(input bit narrow);
        return narrow ? bus8.out_valid : bus32.out_valid;
    endfunction

    function automatic logic get_ready(input bit narrow);
        return narrow ? bus8.in_ready : bus32.in_ready;
    endfunction

    function automatic logic get_busy(input bit narrow);
        return narrow ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic [63:0] get_result(input bit narrow);
        return narrow ? {56'd0, bus8.result} : {32'd0, bus32.result};
    endfunction

    function automatic logic get_zero(input bit narrow);
        return narrow ? bus8.zero : bus32.zero;
    endfunction

    // One request; operands are scrambled after acceptance to show they were captured.
    task automatic apply_stimulus(input bit narrow, input logic [4:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] expected, input string name);
        int w, exp_lat, cyc;
        bit leak;
        w       = narrow ? 8 : 32;
        exp_lat = (op >= OP_MUL && op <= OP_REMU) ? w + 2 : 1;
        drive(narrow, 1'b1, op, a, b);
        check_output({name, " in_ready before accept"}, 64'(get_ready(narrow)), 64'd1);
        @(negedge clk);
        drive(narrow, 1'b0, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        cyc  = 1;
        leak = 1'b0;
        while (!get_valid(narrow) && cyc < 80) begin
            if (get_ready(narrow) !== 1'b0 || get_busy(narrow) !== 1'b1) leak = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check_output({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check_output({name, " result"}, get_result(narrow), expected);
        check_output({name, " zero"}, 64'(get_zero(narrow)), 64'(expected == 64'd0));
        check_output({name, " in_ready with out_valid"}, 64'(get_ready(narrow)), 64'd1);
        if (exp_lat > 1) check_output({name, " stalled while busy"}, 64'(leak), 64'd0);
        @(negedge clk);
        check_output({name, " single pulse"}, 64'(get_valid(narrow)), 64'd0);
        check_output({name, " result held"}, get_result(narrow), expected);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[25];
        int          cyc;
        bit          leak;
        bit          saw;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        checks   = 0;
        failures = 0;
        vecs[0]  = '{OP_ADD,    32'hFFFF_FFFF, 32'h1,         32'h0};
        vecs[1]  = '{OP_SUB,    32'h5,         32'h7,         32'hFFFF_FFFE};
        vecs[2]  = '{OP_SRA,    32'h8000_0000, 32'h24,        32'hF800_0000};
        vecs[3]  = '{OP_SRL,    32'h8000_0000, 32'h24,        32'h0800_0000};
        vecs[4]  = '{OP_SLT,    32'hFFFF_FFFF, 32'h1,         32'h1};
        vecs[5]  = '{OP_SLTU,   32'hFFFF_FFFF, 32'h1,         32'h0};
        vecs[6]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[7]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        vecs[8]  = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
        vecs[9]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[10] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{OP_DIVU,   32'h7,         32'h0,         32'hFFFF_FFFF};
        vecs[12] = '{OP_REMU,   32'h7,         32'h0,         32'h7};
        vecs[13] = '{OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD};
        vecs[14] = '{OP_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF};
        vecs[15] = '{5'd20,     32'h5,         32'h3,         32'h0};
        vecs[16] = '{OP_DIV,    32'h7,         32'h0,         32'hFFFF_FFFF};
        vecs[17] = '{OP_REM,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9};
        vecs[18] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[19] = '{OP_SLL,    32'h1,         32'h21,        32'h2};
        vecs[20] = '{OP_XOR,    32'hF0F0,      32'hFF00,      32'h0FF0};
        vecs[21] = '{OP_DIVU,   32'd100,       32'd7,         32'd14};
        vecs[22] = '{OP_REMU,   32'd100,       32'd7,         32'd2};
        vecs[23] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h1};
        vecs[24] = '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};

        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 5'd0, 64'd0, 64'd0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset in_ready", 64'(bus32.in_ready), 64'd0);
        check_output("reset out_valid", 64'(bus32.out_valid), 64'd0);
        check_output("reset result", 64'(bus32.result), 64'd0);
        check_output("reset zero", 64'(bus32.zero), 64'd1);
        check_output("reset busy", 64'(bus32.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("in_ready after reset", 64'(bus32.in_ready), 64'd1);

        foreach (vecs[i]) begin
            apply_stimulus(1'b0, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), 64'(vecs[i].exp),
                           $sformatf("vec%0d", i));
        end

        // Back-to-back single-cycle requests: ADD then SUB on consecutive cycles.
        drive(1'b0, 1'b1, OP_ADD, 64'hFFFF_FFFF, 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, OP_SUB, 64'd5, 64'd7);
        check_output("b2b add valid", 64'(bus32.out_valid), 64'd1);
        check_output("b2b add result", 64'(bus32.result), 64'd0);
        check_output("b2b add zero", 64'(bus32.zero), 64'd1);
        check_output("b2b add ready", 64'(bus32.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 64'd0, 64'd0);
        check_output("b2b sub valid", 64'(bus32.out_valid), 64'd1);
        check_output("b2b sub result", 64'(bus32.result), 64'hFFFF_FFFE);
        check_output("b2b sub zero", 64'(bus32.zero), 64'd0);
        @(negedge clk);
        check_output("b2b idle valid", 64'(bus32.out_valid), 64'd0);

        // ADD held valid during a DIV: only accepted on the DIV's out_valid cycle.
        drive(1'b0, 1'b1, OP_DIV, 64'hFFFF_FFF9, 64'd2);
        @(negedge clk);
        drive(1'b0, 1'b1, OP_ADD, 64'd3, 64'd4);
        cyc  = 1;
        leak = 1'b0;
        while (!bus32.out_valid && cyc < 80) begin
            if (bus32.in_ready !== 1'b0) leak = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check_output("held add div latency", 64'(cyc), 64'd34);
        check_output("held add div result", 64'(bus32.result), 64'hFFFF_FFFD);
        check_output("held add not accepted early", 64'(leak), 64'd0);
        check_output("held add ready on valid", 64'(bus32.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 64'd0, 64'd0);
        check_output("held add valid", 64'(bus32.out_valid), 64'd1);
        check_output("held add result", 64'(bus32.result), 64'd7);
        @(negedge clk);
        check_output("held add single pulse", 64'(bus32.out_valid), 64'd0);

        // Reset 10 cycles into a DIVU discards it.
        drive(1'b0, 1'b1, OP_DIVU, 64'd100, 64'd7);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 64'd0, 64'd0);
        repeat (9) @(negedge clk);
        check_output("abort busy before reset", 64'(bus32.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort ready during reset", 64'(bus32.in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("abort ready after reset", 64'(bus32.in_ready), 64'd1);
        check_output("abort busy after reset", 64'(bus32.busy), 64'd0);
        check_output("abort result cleared", 64'(bus32.result), 64'd0);
        check_output("abort zero set", 64'(bus32.zero), 64'd1);
        saw = 1'b0;
        repeat (40) begin
            if (bus32.out_valid) saw = 1'b1;
            @(negedge clk);
        end
        check_output("abort no out_valid", 64'(saw), 64'd0);

        apply_stimulus(1'b1, OP_MULHU, 64'hFF, 64'hFF, 64'hFE, "x8 mulhu");

        for (int i = 0; i < 60; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = pick_operand();
            rb  = pick_operand();
            apply_stimulus(1'b0, rop, 64'(ra), 64'(rb), ref_model(rop, 64'(ra), 64'(rb), 32),
                           $sformatf("rnd32_%0d op%0d", i, rop));
        end
        for (int i = 0; i < 40; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = pick_operand();
            rb  = pick_operand();
            apply_stimulus(1'b1, rop, 64'(ra[7:0]), 64'(rb[7:0]), ref_model(rop, 64'(ra), 64'(rb), 8),
                           $sformatf("rnd8_%0d op%0d", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
